// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
//   Owns the byte-addressed instruction memory write/read port of the core.
//   After reset it streams a program image into memory, one byte per
//   LD_VALID/LD_READY handshake. It then zero-fills the rest of memory. The
//   core is held stalled throughout. In RUN, aligned in-range 32-bit
//   big-endian fetches pass through. Misaligned or out-of-range fetches get
//   NOP_WORD and FETCH_FAULT. LD_START in RUN restarts the load.
//
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN
//   When defined, the LD_LAST byte is an 8-bit modular checksum of the image
//   bytes. It is not written and not counted. A mismatch parks the block in
//   ERROR with LOAD_ERR=1 until RESET or LD_START.
//   When undefined, the LD_LAST byte is ordinary data and LOAD_ERR is tied 0.
//
// Ports
//   CLK, RESET          clock (rising edge), asynchronous active-high reset
//   LD_START            restart program load (honoured in RUN/ERROR only)
//   LD_VALID/DATA/LAST  loader byte stream; LD_READY is the accept strobe
//   MEM_WE/WADDR/WDATA  registered byte write port to memory
//   MEM_RADDR/RDATA     combinational word read port (big-endian word)
//   FETCH_ADDR/DATA     IF-stage fetch; FETCH_FAULT flags a substituted NOP
//   CPU_STALL           registered hold for PC and IF/ID register
//   LD_COUNT            bytes accepted in the current load (saturating)
//   LOAD_ERR            checksum mismatch (checksum build only)
// -----------------------------------------------------------------------------
module imem_load_ctrl #(
  parameter int          MEMORY_SIZE = 128,
  parameter int          ADDR_W      = $clog2(MEMORY_SIZE),
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [7:0]        LD_DATA,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_WADDR,
  output logic [7:0]        MEM_WDATA,
  output logic [31:0]       MEM_RADDR,
  input  logic [31:0]       MEM_RDATA,
  input  logic [31:0]       FETCH_ADDR,
  output logic [31:0]       FETCH_DATA,
  output logic              FETCH_FAULT,
  output logic              CPU_STALL,
  output logic [ADDR_W:0]   LD_COUNT,
  output logic              LOAD_ERR
);

  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(MEMORY_SIZE - 1);
  localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(MEMORY_SIZE);
  localparam logic [31:0]       FETCH_MAX = 32'(MEMORY_SIZE - 4);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_CLEAR = 2'd1,
`ifdef IMEM_LOAD_CHECKSUM_EN
    S_RUN   = 2'd2,
    S_ERROR = 2'd3
`else
    S_RUN   = 2'd2
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic              accept;
  logic              byte_wr;
  logic              restart;
  logic              we_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [7:0]        wdata_p1;
  logic              stall_p1;
  logic              fault;
  logic [31:0]       fdata;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]        sum;
  logic              err;
  // The LD_LAST byte carries the checksum and never reaches memory.
  assign byte_wr = accept && !LD_LAST;
`else
  assign byte_wr = accept;
`endif

  assign LD_READY = (state == S_LOAD);
  assign accept   = LD_READY && LD_VALID;
  // Any transition back into LOAD (from RUN or ERROR) starts a fresh image.
  assign restart  = (state != S_LOAD) && (state_nxt == S_LOAD);

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: begin
        if (accept) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          if (LD_LAST)              state_nxt = (LD_DATA == sum) ? S_CLEAR : S_ERROR;
          else if (ptr == PTR_LAST) state_nxt = S_RUN;
`else
          // A full memory needs no fill, regardless of LD_LAST.
          if (ptr == PTR_LAST)      state_nxt = S_RUN;
          else if (LD_LAST)         state_nxt = S_CLEAR;
`endif
        end
      end
      S_CLEAR: if (ptr == PTR_LAST) state_nxt = S_RUN;
      S_RUN:   if (LD_START)        state_nxt = S_LOAD;
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_ERROR: if (LD_START)        state_nxt = S_LOAD;
`endif
      default:                      state_nxt = S_LOAD;
    endcase
  end

  // Stage p1: registered memory write port, pointer, count and stall
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr      <= '0;
      cnt      <= '0;
      we_p1    <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      stall_p1 <= 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum      <= '0;
      err      <= 1'b0;
`endif
    end else begin
      we_p1    <= 1'b0;
      // Stall drops on the very edge that enters RUN.
      stall_p1 <= (state_nxt != S_RUN);
      case (state)
        S_LOAD: begin
          if (byte_wr) begin
            we_p1    <= 1'b1;
            waddr_p1 <= ptr;
            wdata_p1 <= LD_DATA;
            if (ptr != PTR_LAST) ptr <= ptr + 1'b1;
            if (cnt != CNT_MAX)  cnt <= cnt + 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum      <= sum + LD_DATA;
`endif
          end
`ifdef IMEM_LOAD_CHECKSUM_EN
          if (accept && LD_LAST && (LD_DATA != sum)) err <= 1'b1;
`endif
        end
        S_CLEAR: begin
          we_p1    <= 1'b1;
          waddr_p1 <= ptr;
          wdata_p1 <= 8'h00;
          if (ptr != PTR_LAST) ptr <= ptr + 1'b1;
        end
        default: begin
          if (restart) begin
            ptr <= '0;
            cnt <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum <= '0;
            err <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  // Combinational fetch path. A faulting fetch never forwards MEM_RDATA, so
  // the core cannot see bytes from beyond the end of memory.
  always_comb begin
    fault = 1'b0;
    fdata = NOP_WORD;
    if (state == S_RUN) begin
      if ((FETCH_ADDR[1:0] != 2'b00) || (FETCH_ADDR > FETCH_MAX)) fault = 1'b1;
      else                                                        fdata = MEM_RDATA;
    end
  end

  assign MEM_RADDR   = FETCH_ADDR;
  assign FETCH_DATA  = fdata;
  assign FETCH_FAULT = fault;
  assign MEM_WE      = we_p1;
  assign MEM_WADDR   = waddr_p1;
  assign MEM_WDATA   = wdata_p1;
  assign CPU_STALL   = stall_p1;
  assign LD_COUNT    = cnt;
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign LOAD_ERR    = err;
`else
  assign LOAD_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

  localparam int          MS  = 128;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        LD_START;
  logic        LD_VALID;
  logic [7:0]  LD_DATA;
  logic        LD_LAST;
  logic        LD_READY;
  logic        MEM_WE;
  logic [6:0]  MEM_WADDR;
  logic [7:0]  MEM_WDATA;
  logic [31:0] MEM_RADDR;
  logic [31:0] MEM_RDATA;
  logic [31:0] FETCH_ADDR;
  logic [31:0] FETCH_DATA;
  logic        FETCH_FAULT;
  logic        CPU_STALL;
  logic [7:0]  LD_COUNT;
  logic        LOAD_ERR;

  imem_load_ctrl #(.MEMORY_SIZE(MS)) dut (
    .CLK(CLK), .RESET(RESET), .LD_START(LD_START), .LD_VALID(LD_VALID),
    .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .LD_READY(LD_READY),
    .MEM_WE(MEM_WE), .MEM_WADDR(MEM_WADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RADDR(MEM_RADDR), .MEM_RDATA(MEM_RDATA), .FETCH_ADDR(FETCH_ADDR),
    .FETCH_DATA(FETCH_DATA), .FETCH_FAULT(FETCH_FAULT), .CPU_STALL(CPU_STALL),
    .LD_COUNT(LD_COUNT), .LOAD_ERR(LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  // Behavioural byte memory with a combinational big-endian word read.
  logic [7:0] mem [0:MS-1];
  int         wr_cnt = 0;
  logic [6:0] ra;

  always @(posedge CLK) begin
    if (MEM_WE) begin
      mem[MEM_WADDR] <= MEM_WDATA;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always_comb begin
    ra        = MEM_RADDR[6:0];
    MEM_RDATA = 32'hDEAD_BEEF;
    if (MEM_RADDR <= 32'd124)
      MEM_RDATA = {mem[ra], mem[ra + 7'd1], mem[ra + 7'd2], mem[ra + 7'd3]};
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input int gap);
    LD_VALID = 1'b1;
    LD_DATA  = d;
    LD_LAST  = last;
    tick();
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_start();
    LD_START = 1'b1;
    tick();
    LD_START = 1'b0;
  endtask

  task automatic wait_run(input int max, output int n);
    n = 0;
    while (CPU_STALL && n < max) begin
      tick();
      n++;
    end
    chk("run_reached", {31'b0, CPU_STALL}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
  } fvec_t;

  fvec_t       fv [9];
  logic [31:0] fib [7];
  logic [31:0] w;
  int          n;
  int          base;

  initial begin
    fib[0] = 32'h0000_0093; fib[1] = 32'h0010_0113; fib[2] = 32'h00A0_0293;
    fib[3] = 32'h0020_81B3; fib[4] = 32'h0001_0093; fib[5] = 32'h0001_8113;
    fib[6] = 32'hFE51_9AE3;

    // Fetch vectors after the fib image is loaded and zero-filled.
    fv[0] = '{32'd0,   32'h0000_0093, 1'b0};
    fv[1] = '{32'd4,   32'h0010_0113, 1'b0};
    fv[2] = '{32'd24,  32'hFE51_9AE3, 1'b0};
    fv[3] = '{32'd28,  32'h0000_0000, 1'b0};
    fv[4] = '{32'd124, 32'h0000_0000, 1'b0};
    fv[5] = '{32'd2,   NOP,           1'b1};
    fv[6] = '{32'd126, NOP,           1'b1};
    fv[7] = '{32'd128, NOP,           1'b1};
    fv[8] = '{32'd1,   NOP,           1'b1};

    RESET = 1'b1; LD_START = 1'b0; LD_VALID = 1'b0; LD_DATA = 8'h00;
    LD_LAST = 1'b0; FETCH_ADDR = 32'd2;
    repeat (3) tick();
    RESET = 1'b0;
    #1;

    // Reset state
    chk("rst_ready",  {31'b0, LD_READY},    32'd1);
    chk("rst_stall",  {31'b0, CPU_STALL},   32'd1);
    chk("rst_count",  {24'b0, LD_COUNT},    32'd0);
    chk("rst_we",     {31'b0, MEM_WE},      32'd0);
    chk("rst_waddr",  {25'b0, MEM_WADDR},   32'd0);
    chk("rst_wdata",  {24'b0, MEM_WDATA},   32'd0);
    chk("rst_err",    {31'b0, LOAD_ERR},    32'd0);
    chk("rst_fdata",  FETCH_DATA,           NOP);
    chk("rst_ffault", {31'b0, FETCH_FAULT}, 32'd0);

`ifdef IMEM_LOAD_CHECKSUM_EN
    // Good checksum: 0x01 + 0x02 == 0x03
    send(8'h01, 1'b0, 0);
    send(8'h02, 1'b0, 0);
    send(8'h03, 1'b1, 0);
    wait_run(200, n);
    tick();
    chk("ck_count", {24'b0, LD_COUNT}, 32'd2);
    chk("ck_err0",  {31'b0, LOAD_ERR}, 32'd0);
    FETCH_ADDR = 32'd0; #1;
    chk("ck_fetch0", FETCH_DATA, 32'h0102_0000);
    // Bad checksum parks in ERROR.
    pulse_start();
    send(8'h01, 1'b0, 0);
    send(8'h02, 1'b0, 0);
    send(8'h04, 1'b1, 0);
    repeat (3) tick();
    chk("ck_err1",   {31'b0, LOAD_ERR},  32'd1);
    chk("ck_stall",  {31'b0, CPU_STALL}, 32'd1);
    chk("ck_ready0", {31'b0, LD_READY},  32'd0);
    pulse_start();
    chk("ck_err_clr", {31'b0, LOAD_ERR}, 32'd0);
    chk("ck_ready1",  {31'b0, LD_READY}, 32'd1);
`else
    // Test 1: fib image, LD_VALID held high, then zero-fill.
    base = wr_cnt;
    for (int i = 0; i < 28; i++) begin
      w = fib[i / 4];
      send(w[31 - 8 * (i % 4) -: 8], (i == 27), 0);
    end
    chk("t1_count", {24'b0, LD_COUNT}, 32'd28);
    chk("t1_ready_clear", {31'b0, LD_READY}, 32'd0);
    wait_run(200, n);
    chk("t1_clear_cycles", n, 32'd100);
    tick();
    chk("t1_writes", wr_cnt - base, 32'd128);

    // Test 2: table-driven fetches
    for (int i = 0; i < 9; i++) begin
      FETCH_ADDR = fv[i].addr;
      #1;
      chk($sformatf("fetch_data_%0d", fv[i].addr), FETCH_DATA, fv[i].data);
      chk($sformatf("fetch_fault_%0d", fv[i].addr), {31'b0, FETCH_FAULT}, {31'b0, fv[i].fault});
    end
    FETCH_ADDR = 32'd2;

    // Test 5: LD_START from RUN
    pulse_start();
    chk("t5_stall", {31'b0, CPU_STALL},   32'd1);
    chk("t5_count", {24'b0, LD_COUNT},    32'd0);
    chk("t5_ready", {31'b0, LD_READY},    32'd1);
    chk("t5_fault", {31'b0, FETCH_FAULT}, 32'd0);

    // Test 3: gapped full image, no LD_LAST, no fill
    base = wr_cnt;
    for (int i = 0; i < 127; i++) send(8'(i * 3 + 1), 1'b0, 2);
    chk("t3_stall_before", {31'b0, CPU_STALL}, 32'd1);
    send(8'(127 * 3 + 1), 1'b0, 0);
    chk("t3_stall_after", {31'b0, CPU_STALL}, 32'd0);
    chk("t3_count", {24'b0, LD_COUNT}, 32'd128);
    repeat (4) tick();
    chk("t3_writes", wr_cnt - base, 32'd128);
    FETCH_ADDR = 32'd0;   #1;
    chk("t3_fetch0", FETCH_DATA, 32'h0104_070A);
    FETCH_ADDR = 32'd124; #1;
    chk("t3_fetch124", FETCH_DATA, 32'h7578_7B7E);

    // Test 4: async reset mid-load, then short reload with fill
    pulse_start();
    for (int i = 0; i < 10; i++) send(8'hAA, 1'b0, 0);
    #3 RESET = 1'b1;
    #1;
    chk("t4_async_count", {24'b0, LD_COUNT}, 32'd0);
    chk("t4_async_we",    {31'b0, MEM_WE},   32'd0);
    #1 RESET = 1'b0;
    tick();
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    send(8'h33, 1'b0, 0);
    send(8'h44, 1'b1, 0);
    // LD_VALID and LD_START must be ignored during CLEAR.
    LD_VALID = 1'b1; LD_START = 1'b1;
    tick(); tick();
    chk("t4_clear_ready", {31'b0, LD_READY}, 32'd0);
    chk("t4_clear_count", {24'b0, LD_COUNT}, 32'd4);
    LD_VALID = 1'b0; LD_START = 1'b0;
    wait_run(200, n);
    tick();
    FETCH_ADDR = 32'd0; #1;
    chk("t4_fetch0", FETCH_DATA, 32'h1122_3344);
    FETCH_ADDR = 32'd8; #1;
    chk("t4_fetch8", FETCH_DATA, 32'h0000_0000);
    chk("t4_count",  {24'b0, LD_COUNT}, 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
